// File: rtl/seq_pkg.sv
// Shared types and code-conversion helpers for the selectable-sequence counter.
package seq_pkg;

  typedef enum logic [1:0] {
    MODE_RING    = 2'd0,
    MODE_JOHNSON = 2'd1,
    MODE_BINARY  = 2'd2,
    MODE_GRAY    = 2'd3
  } mode_t;

  localparam int unsigned MaxWidth = 64;
  typedef logic [MaxWidth-1:0] vec_t;

  // Callers zero-extend into vec_t and truncate back, so any width up to MaxWidth works.
  function automatic vec_t bin2gray(input vec_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t gray2bin(input vec_t g);
    vec_t b;
    b = g;
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/seq_step_logic.sv
// Combinational one-step successor/predecessor for every sequence mode, plus boundary flag.
module seq_step_logic
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_state,
  input  mode_t            i_mode,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next,
  output logic             o_boundary
);

  logic [WIDTH-1:0] w_seed;
  logic             w_onehot;

  assign w_seed   = (i_mode == MODE_RING) ? WIDTH'(1) : '0;
  assign w_onehot = (i_state != '0) && ((i_state & (i_state - WIDTH'(1))) == '0);

  always_comb begin
    o_next = i_state;
    unique case (i_mode)
      MODE_RING: begin
        if (!w_onehot) begin
          o_next = w_seed;
        end else if (i_up) begin
          o_next = {i_state[WIDTH-2:0], i_state[WIDTH-1]};
        end else begin
          o_next = {i_state[0], i_state[WIDTH-1:1]};
        end
      end
      MODE_JOHNSON: begin
        if (i_up) o_next = {i_state[WIDTH-2:0], ~i_state[WIDTH-1]};
        else      o_next = {~i_state[0], i_state[WIDTH-1:1]};
      end
      MODE_BINARY, MODE_GRAY: begin
        // Gray mode steps its internal binary value; conversion happens at the output register.
        if (i_up) o_next = i_state + WIDTH'(1);
        else      o_next = i_state - WIDTH'(1);
      end
    endcase
  end

  assign o_boundary = i_up ? (o_next == w_seed) : (i_state == w_seed);

endmodule

// File: rtl/seq_counter.sv
// Selectable ring/Johnson/binary/Gray sequencer with direction, enable, checked load and wrap pulse.
module seq_counter
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  mode_t            i_mode,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap,
  output logic             o_load_err
);

  mode_t            r_mode;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_load_err;

  mode_t            w_mode_d;
  logic [WIDTH-1:0] w_bin_d;
  logic [WIDTH-1:0] w_count_d;
  logic             w_wrap_d;
  logic             w_err_d;
  logic [WIDTH-1:0] w_next;
  logic             w_boundary;
  logic [WIDTH-1:0] w_lv_inv;
  logic             w_ring_ok;
  logic             w_john_ok;

  function automatic logic [WIDTH-1:0] seed(input mode_t m);
    return (m == MODE_RING) ? WIDTH'(1) : '0;
  endfunction

  seq_step_logic #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_state   (r_bin),
    .i_mode    (r_mode),
    .i_up      (i_up),
    .o_next    (w_next),
    .o_boundary(w_boundary)
  );

  assign w_lv_inv  = ~i_load_value;
  assign w_ring_ok = (i_load_value != '0) &&
                     ((i_load_value & (i_load_value - WIDTH'(1))) == '0);
  // Legal Johnson codes are a run of ones anchored at the LSB, or its complement.
  assign w_john_ok = ((i_load_value & (i_load_value + WIDTH'(1))) == '0) ||
                     ((w_lv_inv & (w_lv_inv + WIDTH'(1))) == '0);

  always_comb begin
    w_mode_d = r_mode;
    w_bin_d  = r_bin;
    w_wrap_d = 1'b0;
    w_err_d  = 1'b0;
    if (i_mode != r_mode) begin
      w_mode_d = i_mode;
      w_bin_d  = seed(i_mode);
    end else if (i_load) begin
      unique case (r_mode)
        MODE_RING: begin
          w_bin_d = w_ring_ok ? i_load_value : seed(MODE_RING);
          w_err_d = !w_ring_ok;
        end
        MODE_JOHNSON: begin
          w_bin_d = w_john_ok ? i_load_value : seed(MODE_JOHNSON);
          w_err_d = !w_john_ok;
        end
        MODE_BINARY: w_bin_d = i_load_value;
        MODE_GRAY:   w_bin_d = WIDTH'(gray2bin(vec_t'(i_load_value)));
      endcase
    end else if (i_en) begin
      w_bin_d  = w_next;
      w_wrap_d = w_boundary;
    end
    w_count_d = (w_mode_d == MODE_GRAY) ? WIDTH'(bin2gray(vec_t'(w_bin_d))) : w_bin_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode     <= MODE_RING;
      r_bin      <= WIDTH'(1);
      r_count    <= WIDTH'(1);
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_mode     <= w_mode_d;
      r_bin      <= w_bin_d;
      r_count    <= w_count_d;
      r_wrap     <= w_wrap_d;
      r_load_err <= w_err_d;
    end
  end

  assign o_count    = r_count;
  assign o_wrap     = r_wrap;
  assign o_load_err = r_load_err;

endmodule

// File: tb/tb_seq_counter.sv
// Directed plus randomized bench; the model tracks a position index within each sequence.
module tb_seq_counter;
  import seq_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_value;
  mode_t        mode;
  logic [W-1:0] count;
  logic         wrap;
  logic         load_err;

  int    n_tests = 0;
  int    n_fail  = 0;
  mode_t m_mode;
  int    m_idx;
  logic  m_wrap;
  logic  m_err;

  seq_counter #(
    .WIDTH(W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_up        (up),
    .i_load      (load),
    .i_load_value(load_value),
    .i_mode      (mode),
    .o_count     (count),
    .o_wrap      (wrap),
    .o_load_err  (load_err)
  );

  always #5 clk = ~clk;

  function automatic int period(input mode_t m);
    case (m)
      MODE_RING:    return W;
      MODE_JOHNSON: return 2 * W;
      default:      return 1 << W;
    endcase
  endfunction

  // Pattern shown at position k of each sequence; position 0 is always the seed.
  function automatic logic [W-1:0] pat(input mode_t m, input int k);
    int v;
    case (m)
      MODE_RING:    v = 1 << k;
      MODE_JOHNSON: v = (k <= W) ? ((1 << k) - 1) : (((1 << W) - 1) & ~((1 << (k - W)) - 1));
      MODE_BINARY:  v = k;
      default:      v = k ^ (k >> 1);
    endcase
    return W'(v);
  endfunction

  task automatic model_reset();
    m_mode = MODE_RING;
    m_idx  = 0;
    m_wrap = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_step();
    int p;
    bit found;
    p = period(m_mode);
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (mode != m_mode) begin
      m_mode = mode;
      m_idx  = 0;
    end else if (load) begin
      found = 1'b0;
      for (int k = 0; k < p; k++) begin
        if (!found && pat(m_mode, k) == load_value) begin
          found = 1'b1;
          m_idx = k;
        end
      end
      if (!found) begin
        m_idx = 0;
        m_err = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        m_idx  = (m_idx + 1) % p;
        m_wrap = (m_idx == 0);
      end else begin
        m_wrap = (m_idx == 0);
        m_idx  = (m_idx + p - 1) % p;
      end
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("count", count, pat(m_mode, m_idx));
    check("wrap", W'(wrap), W'(m_wrap));
    check("load_err", W'(load_err), W'(m_err));
  endtask

  task automatic drive(input logic e, input logic u, input logic l, input logic [W-1:0] lv,
                       input mode_t md);
    en         = e;
    up         = u;
    load       = l;
    load_value = lv;
    mode       = md;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
    end
  endtask

  // Assert reset between edges, check outputs at once, release before the next edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, '0, MODE_RING);
    model_reset();
    #12;
    check_all();
    check("reset_count", count, 4'b0001);
    rst_n = 1'b1;

    // Ring up, then down across the boundary, then hold
    drive(1'b1, 1'b1, 1'b0, '0, MODE_RING);
    tick(4);
    up = 1'b0;
    tick(4);
    en = 1'b0;
    tick(3);

    // Johnson full period after a mode change
    drive(1'b1, 1'b1, 1'b0, '0, MODE_JOHNSON);
    tick(9);

    // Loads: illegal ring, illegal/legal Johnson, load beats enable
    drive(1'b0, 1'b1, 1'b0, '0, MODE_RING);
    tick(1);
    drive(1'b0, 1'b1, 1'b1, 4'b0110, MODE_RING);
    tick(1);
    drive(1'b0, 1'b1, 1'b0, '0, MODE_JOHNSON);
    tick(1);
    drive(1'b0, 1'b1, 1'b1, 4'b0101, MODE_JOHNSON);
    tick(1);
    drive(1'b0, 1'b1, 1'b1, 4'b0011, MODE_JOHNSON);
    tick(1);
    drive(1'b1, 1'b1, 1'b1, 4'b1110, MODE_JOHNSON);
    tick(1);
    check("load_beats_en", count, 4'b1110);

    // Gray up, binary wrap both ways
    drive(1'b1, 1'b1, 1'b0, '0, MODE_GRAY);
    tick(5);
    check("gray_4th", count, 4'b0110);
    drive(1'b0, 1'b0, 1'b0, '0, MODE_BINARY);
    tick(1);
    en = 1'b1;
    tick(1);
    up = 1'b1;
    tick(1);

    // Async reset mid-sequence in binary mode, then mode-change path on first edge
    drive(1'b0, 1'b1, 1'b1, 4'b0101, MODE_BINARY);
    tick(1);
    drive(1'b1, 1'b1, 1'b0, '0, MODE_BINARY);
    async_reset();
    tick(1);
    check("post_reset_bin", count, 4'b0000);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      mode_t md;
      r  = int'($urandom_range(0, 99));
      md = mode;
      if (r < 6) md = mode_t'($urandom_range(0, 3));
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1) != 0;
      load = (r >= 6 && r < 22);
      load_value = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 15))
                                               : pat(md, int'($urandom_range(0, period(md) - 1)));
      mode = md;
      if (r == 99) async_reset();
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
